rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Arbitrates one shared memory port between instruction fetch and load/store. Drives the immediate generator's type select, ALU operand and op selects, register-file and PC write enables, and the write-back mux. Sits between the instruction register and the existing combinational datapath units.

Parameters:
TIMEOUT, 255, max cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
inst  in  32  instruction register contents; opcode inst[6:0], funct3 inst[14:12]
br_taken  in  1  branch comparator result, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  store when 1, read when 0
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  latch mem_rdata into the IR
pc_we  out  1  PC update
pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1
imm_type  out  3  immediate-generator select; 000 none, 001 I, 110 I-ALU/shift, 010 U, 011 B, 100 S, 101 J
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm
alu_op_sel  out  2  0 = add, 1 = funct-decoded (OP/OP-IMM), 2 = pass B (LUI)
rf_we  out  1  register-file write
wb_sel  out  2  0 = ALU, 1 = mem_rdata, 2 = PC+4
illegal  out  1  sticky trap flag
instret  out  32  retired-instruction counter
state  out  3  current FSM state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. State register and counters are the only sequential elements. All control outputs are Moore outputs of the state and IR opcode.
- Reset (rst_n=0 at an edge): state=IDLE, timeout counter=0, instret=0, illegal=0.
  - In IDLE every control output is 0, including imm_type=000.
  - IDLE goes to FETCH unconditionally on the next edge.
- Reset asserted mid-access abandons the access: mem_req is 0 from the cycle after that edge. No PC or RF write happens in the reset cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0.
  - ir_we = mem_ready in the same cycle.
  - On mem_ready, go to DECODE. Otherwise stay.
- DECODE: imm_type is driven from opcode starting here and held through EXEC/MEM/WB.
  - Mapping: OP-IMM→110; LOAD and JALR→001; LUI and AUIPC→010; BRANCH→011; STORE→100; JAL→101; OP→000.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - Any other opcode goes to TRAP. Otherwise go to EXEC.
- EXEC, by opcode:
  - BRANCH: pc_we=1, pc_src = br_taken ? 1 : 0. Retire, then FETCH.
  - JAL: rf_we=1, wb_sel=2, pc_we=1, pc_src=1. Retire, then FETCH.
  - JALR: rf_we=1, wb_sel=2, pc_we=1, pc_src=2. Retire, then FETCH.
  - LOAD/STORE: alu_b_sel=1, alu_op_sel=0. Go to MEM.
  - OP/OP-IMM/LUI/AUIPC: select operands (AUIPC: alu_a_sel=1; LUI: alu_op_sel=2). Go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). Operand selects are held.
  - Wait for mem_ready.
  - STORE: pc_we=1, pc_src=0 in the ready cycle. Retire, then FETCH.
  - LOAD: go to WB.
- WB: rf_we=1, wb_sel=1 for LOAD, otherwise 0. pc_we=1, pc_src=0. Retire, then FETCH.
- rd=x0 is not special-cased; the register file discards the write.
- Retire: instret increments by 1 on the retiring edge. It wraps 0xFFFFFFFF→0.
- Timeout:
  - The counter increments on each cycle with mem_req=1 and mem_ready=0, and clears on mem_ready or state change.
  - When the counter equals TIMEOUT with mem_ready still 0, go to TRAP.
  - mem_ready in that same cycle wins: the access completes normally.
- TRAP: illegal=1. All enables and mem_req are 0. instret is frozen. Only reset exits TRAP.
- Latency from FETCH entry, with zero-wait memory:
  - Branch/jump: 3 cycles.
  - ALU, LUI, AUIPC, store: 4 cycles.
  - Load: 5 cycles.

Decomposition:
- Shared package holds:
  - opcode constants;
  - imm_type encodings, shared with the immediate generator;
  - the state enum;
  - pc_src, wb_sel and alu_op_sel encodings.
- One sub-module, rv32i_opcode_dec: combinational opcode → {legal, imm_type, class}. It is reused by the FSM's DECODE and output logic.

Test Plan:
- Reset: rst_n low 2 cycles → state=0, all outputs 0, instret=0. Cycle after release → FETCH, mem_req=1.
- Zero-wait addi (0x00500093) → ir_we in FETCH, imm_type=110 from DECODE, rf_we=1 and wb_sel=0 in WB, instret=1 after 4 cycles.
- Load lw (0x0000A103), mem_ready delayed 3 cycles in MEM → mem_addr_sel=1, mem_we=0 held; WB with wb_sel=1 exactly 1 cycle after ready; total 8 cycles.
- Branch beq (0x00000463): br_taken=1 → pc_src=1; br_taken=0 → pc_src=0; imm_type=011; both retire in 3 cycles.
- Illegal opcode 0x0000007F → TRAP after DECODE, illegal=1 sticky for 20 cycles; rst_n pulse clears it.
- TIMEOUT=4, mem_ready never asserted in FETCH → TRAP on the 5th wait-cycle edge. Repeat with mem_ready in that same cycle → DECODE, no trap.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer.
// Opcodes, immediate-type selects, FSM states and datapath mux codes.
package rv32i_multicycle_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_U    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_S    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;
   localparam logic [2:0] IMM_IALU = 3'b110;

   localparam logic [1:0] PC_4   = 2'd0;
   localparam logic [1:0] PC_IMM = 2'd1;
   localparam logic [1:0] PC_JR  = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_FUNCT = 2'd1;
   localparam logic [1:0] ALU_PASSB = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR,
      C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP
   } cls_t;

endpackage

// File: rtl/rv32i_opcode_dec.sv
// Combinational opcode decoder: legality, immediate type and
// instruction class for the control FSM.
module rv32i_opcode_dec
   import rv32i_multicycle_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic       o_legal,
   output logic [2:0] o_imm_type,
   output cls_t       o_cls
);

   always_comb begin
      o_legal    = 1'b1;
      o_imm_type = IMM_NONE;
      o_cls      = C_NONE;
      case (i_opcode)
         OPC_LUI:    begin o_imm_type = IMM_U;    o_cls = C_LUI;    end
         OPC_AUIPC:  begin o_imm_type = IMM_U;    o_cls = C_AUIPC;  end
         OPC_JAL:    begin o_imm_type = IMM_J;    o_cls = C_JAL;    end
         OPC_JALR:   begin o_imm_type = IMM_I;    o_cls = C_JALR;   end
         OPC_BRANCH: begin o_imm_type = IMM_B;    o_cls = C_BRANCH; end
         OPC_LOAD:   begin o_imm_type = IMM_I;    o_cls = C_LOAD;   end
         OPC_STORE:  begin o_imm_type = IMM_S;    o_cls = C_STORE;  end
         OPC_OPIMM:  begin o_imm_type = IMM_IALU; o_cls = C_OPIMM;  end
         OPC_OP:     begin o_imm_type = IMM_NONE; o_cls = C_OP;     end
         default:    o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath,
// sharing one memory port between instruction fetch and load/store.
module rv32i_multicycle_ctrl
   import rv32i_multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [2:0]  imm_type,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [1:0]  alu_op_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [31:0] instret,
   output logic [2:0]  state
);

   state_t          r_state;
   state_t          w_next;
   logic [TO_W-1:0] r_to;
   logic [31:0]     r_instret;
   logic            r_illegal;
   logic            w_legal;
   logic [2:0]      w_imm;
   cls_t            w_cls;
   logic            w_retire;
   logic            w_to_hit;
   logic            w_pc_we;
   logic            w_rf_we;
   logic            w_unused;

   assign w_unused = ^inst[31:7];

   rv32i_opcode_dec u_dec (
      .i_opcode   (inst[6:0]),
      .o_legal    (w_legal),
      .o_imm_type (w_imm),
      .o_cls      (w_cls)
   );

   // ready in the deadline cycle still completes the access
   assign w_to_hit = (TIMEOUT != 0) && (r_to == TO_W'(TIMEOUT))
                     && !mem_ready;

   always_comb begin
      w_next       = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      w_pc_we      = 1'b0;
      pc_src       = PC_4;
      imm_type     = IMM_NONE;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      alu_op_sel   = ALU_ADD;
      w_rf_we      = 1'b0;
      wb_sel       = WB_ALU;
      w_retire     = 1'b0;

      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
         imm_type = w_imm;

      // operand selects stay stable until the result is consumed
      if (r_state inside {S_EXEC, S_MEM, S_WB}) begin
         case (w_cls)
            C_LOAD, C_STORE: alu_b_sel = 1'b1;
            C_OPIMM: begin
               alu_b_sel  = 1'b1;
               alu_op_sel = ALU_FUNCT;
            end
            C_OP:    alu_op_sel = ALU_FUNCT;
            C_LUI: begin
               alu_b_sel  = 1'b1;
               alu_op_sel = ALU_PASSB;
            end
            C_AUIPC: begin
               alu_a_sel = 1'b1;
               alu_b_sel = 1'b1;
            end
            default: ;
         endcase
      end

      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            if (mem_ready)     w_next = S_DECODE;
            else if (w_to_hit) w_next = S_TRAP;
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (w_cls)
               C_BRANCH: begin
                  w_pc_we  = 1'b1;
                  pc_src   = br_taken ? PC_IMM : PC_4;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
               C_JAL, C_JALR: begin
                  w_rf_we  = 1'b1;
                  wb_sel   = WB_PC4;
                  w_pc_we  = 1'b1;
                  pc_src   = (w_cls == C_JAL) ? PC_IMM : PC_JR;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
               C_LOAD, C_STORE: w_next = S_MEM;
               C_NONE:          w_next = S_TRAP;
               default:         w_next = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (w_cls == C_STORE);
            if (mem_ready) begin
               if (w_cls == C_STORE) begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_to_hit) begin
               w_next = S_TRAP;
            end
         end
         S_WB: begin
            w_rf_we  = 1'b1;
            wb_sel   = (w_cls == C_LOAD) ? WB_MEM : WB_ALU;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_IDLE;
      endcase
   end

   assign pc_we   = w_pc_we & rst_n;
   assign rf_we   = w_rf_we & rst_n;
   assign illegal = r_illegal;
   assign instret = r_instret;
   assign state   = r_state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_to      <= '0;
         r_instret <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || !mem_req || mem_ready)
            r_to <= '0;
         else
            r_to <= r_to + TO_W'(1);
         if (w_retire)
            r_instret <= r_instret + 32'd1;
         if (w_next == S_TRAP)
            r_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for the multi-cycle control sequencer.
// Expected control words are queued as stimulus is applied.
module tb_rv32i_multicycle_ctrl;

   localparam logic [2:0] SI = 3'd0;
   localparam logic [2:0] SF = 3'd1;
   localparam logic [2:0] SD = 3'd2;
   localparam logic [2:0] SX = 3'd3;
   localparam logic [2:0] SM = 3'd4;
   localparam logic [2:0] SW = 3'd5;
   localparam logic [2:0] ST = 3'd6;

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] LW   = 32'h0000A103;
   localparam logic [31:0] BEQ  = 32'h00000463;
   localparam logic [31:0] SWI  = 32'h00112023;
   localparam logic [31:0] JAL  = 32'h008000EF;
   localparam logic [31:0] BAD  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        br_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
   logic [1:0]  pc_src, alu_op_sel, wb_sel;
   logic [2:0]  imm_type, state;
   logic        alu_a_sel, alu_b_sel, rf_we, illegal;
   logic [31:0] instret;
   logic [20:0] act;

   typedef struct {
      string       nm;
      logic        rst;
      logic [31:0] ins;
      logic        br;
      logic        rdy;
      logic [20:0] ex;
      logic [31:0] ret;
   } vec_t;

   typedef struct {
      string       nm;
      logic [20:0] ex;
      logic [31:0] ret;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rv32i_multicycle_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst         (inst),
      .br_taken     (br_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .imm_type     (imm_type),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .alu_op_sel   (alu_op_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .illegal      (illegal),
      .instret      (instret),
      .state        (state)
   );

   assign act = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                 pc_src, imm_type, alu_a_sel, alu_b_sel, alu_op_sel,
                 rf_we, wb_sel, illegal};

   function automatic logic [20:0] E(
      input logic [2:0] st, input logic mq, input logic mw,
      input logic ma, input logic iw, input logic pw,
      input logic [1:0] ps, input logic [2:0] im,
      input logic a, input logic b, input logic [1:0] op,
      input logic rf, input logic [1:0] wb, input logic il);
      return {st, mq, mw, ma, iw, pw, ps, im, a, b, op, rf, wb, il};
   endfunction

   task automatic add(input string nm, input logic rst,
                      input logic [31:0] ins, input logic br,
                      input logic rdy, input logic [20:0] ex,
                      input logic [31:0] ret);
      vec_t v;
      v.nm = nm; v.rst = rst; v.ins = ins; v.br = br;
      v.rdy = rdy; v.ex = ex; v.ret = ret;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   // called just after a rising edge; returns just after the next one
   task automatic step(input vec_t v);
      sb_t s;
      #1;
      rst_n     = v.rst;
      inst      = v.ins;
      br_taken  = v.br;
      mem_ready = v.rdy;
      s.nm = v.nm; s.ex = v.ex; s.ret = v.ret;
      sbq.push_back(s);
      @(negedge clk);
      s = sbq.pop_front();
      chk(s.nm, {11'b0, act}, {11'b0, s.ex});
      chk({s.nm, "_ret"}, instret, s.ret);
      @(posedge clk);
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; inst = '0; br_taken = 1'b0; mem_ready = 1'b0;

      add("rst_idle", 0, 0, 0, 0, E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      add("idle",     1, 0, 0, 0, E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      add("addi_f", 1, ADDI, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 0);
      add("addi_d", 1, ADDI, 0, 0,
          E(SD,0,0,0,0,0,0,3'b110,0,0,0,0,0,0), 0);
      add("addi_x", 1, ADDI, 0, 0,
          E(SX,0,0,0,0,0,0,3'b110,0,1,1,0,0,0), 0);
      add("addi_w", 1, ADDI, 0, 0,
          E(SW,0,0,0,0,1,0,3'b110,0,1,1,1,0,0), 0);
      add("lw_f", 1, LW, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 1);
      add("lw_d", 1, LW, 0, 0, E(SD,0,0,0,0,0,0,3'b001,0,0,0,0,0,0), 1);
      add("lw_x", 1, LW, 0, 0, E(SX,0,0,0,0,0,0,3'b001,0,1,0,0,0,0), 1);
      for (int i = 0; i < 3; i++)
         add("lw_mwait", 1, LW, 0, 0,
             E(SM,1,0,1,0,0,0,3'b001,0,1,0,0,0,0), 1);
      add("lw_mrdy", 1, LW, 0, 1,
          E(SM,1,0,1,0,0,0,3'b001,0,1,0,0,0,0), 1);
      add("lw_w", 1, LW, 0, 0, E(SW,0,0,0,0,1,0,3'b001,0,1,0,1,1,0), 1);
      add("beqt_f", 1, BEQ, 1, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 2);
      add("beqt_d", 1, BEQ, 1, 0,
          E(SD,0,0,0,0,0,0,3'b011,0,0,0,0,0,0), 2);
      add("beqt_x", 1, BEQ, 1, 0,
          E(SX,0,0,0,0,1,1,3'b011,0,0,0,0,0,0), 2);
      add("beqn_f", 1, BEQ, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 3);
      add("beqn_d", 1, BEQ, 0, 0,
          E(SD,0,0,0,0,0,0,3'b011,0,0,0,0,0,0), 3);
      add("beqn_x", 1, BEQ, 0, 0,
          E(SX,0,0,0,0,1,0,3'b011,0,0,0,0,0,0), 3);
      for (int i = 0; i < 4; i++)
         add("sw_fwait", 1, SWI, 0, 0,
             E(SF,1,0,0,0,0,0,0,0,0,0,0,0,0), 4);
      add("sw_frdy_at_limit", 1, SWI, 0, 1,
          E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 4);
      add("sw_d", 1, SWI, 0, 0, E(SD,0,0,0,0,0,0,3'b100,0,0,0,0,0,0), 4);
      add("sw_x", 1, SWI, 0, 0, E(SX,0,0,0,0,0,0,3'b100,0,1,0,0,0,0), 4);
      add("sw_m", 1, SWI, 0, 1, E(SM,1,1,1,0,1,0,3'b100,0,1,0,0,0,0), 4);
      add("jal_f", 1, JAL, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 5);
      add("jal_d", 1, JAL, 0, 0,
          E(SD,0,0,0,0,0,0,3'b101,0,0,0,0,0,0), 5);
      add("jal_x", 1, JAL, 0, 0,
          E(SX,0,0,0,0,1,1,3'b101,0,0,0,1,2,0), 5);
      add("rstf_f", 1, ADDI, 0, 0, E(SF,1,0,0,0,0,0,0,0,0,0,0,0,0), 6);
      add("rstf_rst", 0, ADDI, 0, 0,
          E(SF,1,0,0,0,0,0,0,0,0,0,0,0,0), 6);
      add("rstf_idle", 1, ADDI, 0, 0,
          E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      add("rstw_f", 1, ADDI, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 0);
      add("rstw_d", 1, ADDI, 0, 0,
          E(SD,0,0,0,0,0,0,3'b110,0,0,0,0,0,0), 0);
      add("rstw_x", 1, ADDI, 0, 0,
          E(SX,0,0,0,0,0,0,3'b110,0,1,1,0,0,0), 0);
      add("rstw_wb_nowrite", 0, ADDI, 0, 0,
          E(SW,0,0,0,0,0,0,3'b110,0,1,1,0,0,0), 0);
      add("rstw_idle", 1, ADDI, 0, 0,
          E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      for (int i = 0; i < 5; i++)
         add("to_fwait", 1, ADDI, 0, 0,
             E(SF,1,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      add("to_trap", 1, ADDI, 0, 1, E(ST,0,0,0,0,0,0,0,0,0,0,0,0,1), 0);
      add("to_rst", 0, ADDI, 0, 0, E(ST,0,0,0,0,0,0,0,0,0,0,0,0,1), 0);
      add("to_idle", 1, ADDI, 0, 0, E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);
      add("bad_f", 1, BAD, 0, 1, E(SF,1,0,0,1,0,0,0,0,0,0,0,0,0), 0);
      add("bad_d", 1, BAD, 0, 0, E(SD,0,0,0,0,0,0,0,0,0,0,0,0,0), 0);

      repeat (2) @(posedge clk);
      foreach (tbl[i]) step(tbl[i]);

      // trap must ignore every input until reset
      for (int i = 0; i < 20; i++) begin
         v.nm  = "trap_sticky";
         v.rst = 1'b1;
         v.ins = ($urandom_range(0, 1) == 0) ? ADDI : BAD;
         v.br  = 1'($urandom_range(0, 1));
         v.rdy = 1'($urandom_range(0, 1));
         v.ex  = E(ST,0,0,0,0,0,0,0,0,0,0,0,0,1);
         v.ret = 0;
         step(v);
      end
      v.ins = ADDI; v.br = 1'b0;
      v.nm = "trap_rst"; v.rst = 1'b0; v.rdy = 1'b0;
      v.ex = E(ST,0,0,0,0,0,0,0,0,0,0,0,0,1);
      step(v);
      v.nm = "trap_cleared"; v.rst = 1'b1;
      v.ex = E(SI,0,0,0,0,0,0,0,0,0,0,0,0,0);
      step(v);
      v.nm = "post_rst_fetch";
      v.ex = E(SF,1,0,0,0,0,0,0,0,0,0,0,0,0);
      step(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
